ula_seq: RTL and testbench
==========================

Name: ula_seq

Overview:
- Sequential ALU directly downstream of the ALU control decoder; consumes its 4-bit operation code and shamt select.
- Logic, arithmetic and compare ops complete in one cycle.
- Shifts run serially, one bit per clock, in place of a barrel shifter.
- A start/busy/done handshake lets the datapath stall until the result is ready.

Parameters:
- WIDTH, 32, datapath width in bits (fixed at 32 for MIPS32; SHW = 5 shift-amount bits).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when busy=0.
- operation  input  4  op code from the ALU control decoder.
- shamt  input  1  from decoder: 1 = shift amount taken from shamt_val, 0 = from A[4:0].
- A  input  32  operand rs.
- B  input  32  operand rt; this is the shifted operand for shifts.
- shamt_val  input  5  instruction shamt field.
- busy  output  1  high while a serial shift is in progress.
- done  output  1  one-cycle pulse; result is valid in this cycle.
- result  output  32  registered result; holds until the next completion.
- zero  output  1  (result == 0), derived from the result register.
- overflow  output  1  registered signed overflow; see Optional Feature.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, busy=0, done=0, result=0, zero=1, overflow=0.
- Reset mid-shift aborts the operation: no done pulse, outputs return to reset values.
- Operation codes:
  - 0 add, 1 sub (wrap mod 2^32).
  - 3 and, 4 nor, 5 or, 6 xor.
  - 7 sll, 8 sllv, 9 srl, 10 srlv, 12 sra, 13 srav.
  - 14 slt (signed), 15 sltu (unsigned); result is 32'd1 or 32'd0.
  - 2 and 11 are unused: result=0, 1-cycle latency.
- Shift amount N:
  - shamt=1: N = shamt_val.
  - shamt=0: N = A[4:0].
  - shamt is ignored for non-shift codes.
- FSM states: IDLE, SHIFT.
- IDLE, start=1, non-shift op or N=0:
  - Result computed and registered at that edge; done=1 in the following cycle.
  - Latency is 1.
  - Stay in IDLE.
- IDLE, start=1, shift op with N>0:
  - Load work=B, cnt=N, capture the direction and the arithmetic flag.
  - busy=1; go to SHIFT.
- SHIFT, each edge:
  - work shifts by 1 bit: left with 0 fill; logical right with 0 fill; arithmetic right with sign fill from work[31].
  - cnt decrements.
  - When cnt==1 at the edge: result=shifted value, done=1, busy=0, go to IDLE.
  - done therefore appears exactly N cycles after the start edge; N=31 gives latency 31.
- Operand and opcode inputs are captured at the start edge; later changes during SHIFT have no effect.
- start while busy=1 is ignored; it is not queued.
- Back-to-back: start may be asserted in the cycle done=1, because the FSM is already in IDLE.
- done is high for exactly one cycle per accepted start. result, zero and overflow update only on completion.

Optional Feature:
- Macro ULA_OVERFLOW_EN.
- Defined:
  - On completion of op 0, overflow = (A[31]==B[31]) && (sum[31]!=A[31]).
  - On completion of op 1, overflow = (A[31]!=B[31]) && (diff[31]!=A[31]).
  - Any other completed op clears overflow to 0.
  - result is still written (wrapped value).
- Undefined: overflow port is tied to constant 0; no overflow logic is synthesised.

Test Plan:
- Reset asserted mid-SHIFT (op 7, N=20, reset at cycle 5) -> next cycle busy=0, done=0, result=0, zero=1; no done pulse follows.
- op 0, A=5, B=7, start 1 cycle -> next cycle done=1, result=12, zero=0; op 1 with A=B=9 -> result=0, zero=1.
- op 12 (sra), shamt=1, shamt_val=4, B=32'h80000010 -> busy high 4 cycles, done 4 cycles after start, result=32'hF8000001; start pulses during busy are ignored.
- op 8 (sllv), shamt=0, A[4:0]=0, B=32'h1234 -> done after 1 cycle, result=32'h1234, busy never asserted; then op 10, A[4:0]=31, B=32'h80000000 -> done after 31 cycles, result=1.
- op 14, A=32'hFFFFFFFF, B=1 -> result=1; op 15 same operands -> result=0. Issue the next start in the done cycle -> accepted, done on the following cycle.
- ULA_OVERFLOW_EN defined, op 0, A=32'h7FFFFFFF, B=1 -> result=32'h80000000, overflow=1; following op 3 -> overflow=0. Macro undefined -> overflow stays 0 throughout.

Source files
------------

// File: rtl/ula_seq.sv
// ula_seq: sequential MIPS32 ALU fed by the ALU control decoder.
// Logic, arithmetic and compare ops complete in a single cycle; shifts are
// performed serially, one bit per clock, behind a start/busy/done handshake.
// Optional feature: define ULA_OVERFLOW_EN to register signed add/sub
// overflow. Without it the overflow port is tied to 0.
module ula_seq #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       operation,
    input  logic             shamt,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SHW-1:0]   shamt_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    // Operation codes as produced by the ALU control decoder (2 and 11 unused).
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd3,
        OP_NOR  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_SLL  = 4'd7,
        OP_SLLV = 4'd8,
        OP_SRL  = 4'd9,
        OP_SRLV = 4'd10,
        OP_SRA  = 4'd12,
        OP_SRAV = 4'd13,
        OP_SLT  = 4'd14,
        OP_SLTU = 4'd15
    } op_t;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] work;          // operand being shifted
    logic [SHW-1:0]   cnt;           // shifts still to perform
    logic             shift_left;    // captured direction
    logic             shift_arith;   // captured sign-fill flag

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] fast_result;
    logic [SHW-1:0]   shift_n;
    logic             is_shift;
    logic             is_left;
    logic             is_arith;
    logic [WIDTH-1:0] work_next;
    logic             fast_done;     // single-cycle completion at this edge
    logic             shift_load;    // serial shift accepted at this edge
    logic             shift_last;    // final serial step at this edge

    assign sum  = A + B;
    assign diff = A - B;

    // Shift amount comes from the instruction field or from rs[4:0].
    assign shift_n = shamt ? shamt_val : A[SHW-1:0];

    // Decode the op and compute every single-cycle result.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        fast_result = '0;
        is_shift    = 1'b0;
        is_left     = 1'b0;
        is_arith    = 1'b0;
        case (operation)
            OP_ADD:  fast_result = sum;
            OP_SUB:  fast_result = diff;
            OP_AND:  fast_result = A & B;
            OP_NOR:  fast_result = ~(A | B);
            OP_OR:   fast_result = A | B;
            OP_XOR:  fast_result = A ^ B;
            OP_SLT:  fast_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: fast_result = {{(WIDTH-1){1'b0}}, (A < B)};
            // A zero-length shift completes in one cycle with B unchanged.
            OP_SLL, OP_SLLV: begin
                fast_result = B;
                is_shift    = 1'b1;
                is_left     = 1'b1;
            end
            OP_SRL, OP_SRLV: begin
                fast_result = B;
                is_shift    = 1'b1;
            end
            OP_SRA, OP_SRAV: begin
                fast_result = B;
                is_shift    = 1'b1;
                is_arith    = 1'b1;
            end
            default: fast_result = '0;
        endcase
    end

    // One serial step of the captured shift.
    always_comb begin
        if (shift_left) begin
            work_next = {work[WIDTH-2:0], 1'b0};
        end else begin
            work_next = {shift_arith & work[WIDTH-1], work[WIDTH-1:1]};
        end
    end

    assign fast_done  = (state == IDLE) && start && !(is_shift && (shift_n != '0));
    assign shift_load = (state == IDLE) && start && is_shift && (shift_n != '0);
    assign shift_last = (state == SHIFT) && (cnt == SHW'(1));

    // Control FSM with registered busy/done/result.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples values from before the edge, regardless of statement order.
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            work        <= '0;
            cnt         <= '0;
            shift_left  <= 1'b0;
            shift_arith <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (fast_done) begin
                        result <= fast_result;
                        done   <= 1'b1;
                    end else if (shift_load) begin
                        work        <= B;
                        cnt         <= shift_n;
                        shift_left  <= is_left;
                        shift_arith <= is_arith;
                        busy        <= 1'b1;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    work <= work_next;
                    cnt  <= cnt - SHW'(1);
                    if (shift_last) begin
                        result <= work_next;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign zero = (result == '0);

`ifdef ULA_OVERFLOW_EN
    logic ovf_add;
    logic ovf_sub;
    logic ovf_reg;

    assign ovf_add = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    assign ovf_sub = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);

    // Overflow flag updates only when an operation completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_reg <= 1'b0;
        end else if (fast_done) begin
            ovf_reg <= (operation == OP_ADD) ? ovf_add :
                       (operation == OP_SUB) ? ovf_sub : 1'b0;
        end else if (shift_last) begin
            ovf_reg <= 1'b0;
        end
    end

    assign overflow = ovf_reg;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_ula_seq.sv
// Self-checking bench for ula_seq: directed cases followed by randomized
// operations compared against an arithmetic reference model.
module tb_ula_seq;

    localparam bit OVF_EN =
`ifdef ULA_OVERFLOW_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  operation;
    logic        shamt;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt_val;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    ula_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .operation (operation),
        .shamt     (shamt),
        .A         (a),
        .B         (b),
        .shamt_val (shamt_val),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_shift_op(input logic [3:0] op);
        return op inside {4'd7, 4'd8, 4'd9, 4'd10, 4'd12, 4'd13};
    endfunction

    // Reference result from the instruction semantics.
    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic sh,
                                               input logic [31:0] x, input logic [31:0] y,
                                               input logic [4:0] sv);
        logic [4:0] n;
        n = sh ? sv : x[4:0];
        case (op)
            4'd0:         return x + y;
            4'd1:         return x - y;
            4'd3:         return x & y;
            4'd4:         return ~(x | y);
            4'd5:         return x | y;
            4'd6:         return x ^ y;
            4'd7, 4'd8:   return y << n;
            4'd9, 4'd10:  return y >> n;
            4'd12, 4'd13: return 32'($signed(y) >>> n);
            4'd14:        return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd15:        return (x < y) ? 32'd1 : 32'd0;
            default:      return 32'd0;
        endcase
    endfunction

    // Signed overflow: the exact mathematical result leaves the int32 range.
    function automatic logic ref_ovf(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (op == 4'd0)      r = sx + sy;
        else if (op == 4'd1) r = sx - sy;
        else                 return 1'b0;
        return OVF_EN && (r > 64'sd2147483647 || r < -64'sd2147483648);
    endfunction

    // Issue one operation at the current negedge and wait for completion.
    // Returns at the negedge where done is observed; while busy, inputs are
    // scrambled and start is pulsed to confirm both are ignored.
    task automatic run_op(input logic [3:0] op, input logic sh, input logic [31:0] x,
                          input logic [31:0] y, input logic [4:0] sv);
        logic [31:0] exp_res;
        logic        exp_ovf;
        logic [4:0]  n;
        int          exp_edge;
        int          cycles;
        int          busy_cnt;
        exp_res  = ref_result(op, sh, x, y, sv);
        exp_ovf  = ref_ovf(op, x, y);
        n        = sh ? sv : x[4:0];
        // Completion is registered at the start edge, or N edges later for a shift.
        exp_edge = (is_shift_op(op) && n != 5'd0) ? int'(n) : 0;
        operation = op;
        shamt     = sh;
        a         = x;
        b         = y;
        shamt_val = sv;
        start     = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        cycles   = 1;
        busy_cnt = 0;
        while (!done && cycles < 40) begin
            if (busy) begin
                busy_cnt++;
                start     = 1'($urandom_range(0, 1));
                operation = 4'($urandom);
                shamt     = 1'($urandom_range(0, 1));
                a         = $urandom;
                b         = $urandom;
                shamt_val = 5'($urandom);
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        check("done_seen", 32'(done), 32'd1);
        check("done_edge", 32'(cycles - 1), 32'(exp_edge));
        check("busy_cycles", 32'(busy_cnt), 32'(exp_edge));
        check("busy_at_done", 32'(busy), 32'd0);
        check("result", result, exp_res);
        check("zero", 32'(zero), 32'(exp_res == 32'd0));
        check("overflow", 32'(overflow), 32'(exp_ovf));
    endtask

    // One idle cycle after a completion: done must have dropped.
    task automatic gap();
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int done_cnt;
        reset     = 1'b1;
        start     = 1'b0;
        operation = 4'd0;
        shamt     = 1'b0;
        a         = 32'd0;
        b         = 32'd0;
        shamt_val = 5'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_ovf", 32'(overflow), 32'd0);

        // Add, leaves a non-zero result before the abort test.
        run_op(4'd0, 1'b0, 32'd5, 32'd7, 5'd0);
        check("add_const", result, 32'd12);
        gap();

        // Reset five cycles into a 20-bit sll aborts it silently.
        operation = 4'd7;
        shamt     = 1'b1;
        shamt_val = 5'd20;
        a         = 32'd0;
        b         = 32'h0000_00FF;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_zero", 32'(zero), 32'd1);
        done_cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);

        // Sub to zero.
        run_op(4'd1, 1'b0, 32'd9, 32'd9, 5'd0);
        gap();

        // sra by shamt_val=4.
        run_op(4'd12, 1'b1, 32'h0000_0003, 32'h8000_0010, 5'd4);
        check("sra_const", result, 32'hF800_0001);
        gap();

        // sllv by zero completes immediately; srlv by 31 is the longest shift.
        run_op(4'd8, 1'b0, 32'h0000_0000, 32'h0000_1234, 5'd9);
        check("sllv0_const", result, 32'h0000_1234);
        gap();
        run_op(4'd10, 1'b0, 32'h0000_001F, 32'h8000_0000, 5'd0);
        check("srlv31_const", result, 32'd1);
        gap();

        // slt/sltu issued back to back in the done cycle.
        run_op(4'd14, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd0);
        check("slt_const", result, 32'd1);
        run_op(4'd15, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd0);
        check("sltu_const", result, 32'd0);
        gap();

        // Overflowing add, then a logic op clears the flag.
        run_op(4'd0, 1'b0, 32'h7FFF_FFFF, 32'd1, 5'd0);
        check("ovf_add_const", 32'(overflow), 32'(OVF_EN));
        run_op(4'd3, 1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0);
        check("ovf_clear", 32'(overflow), 32'd0);
        gap();

        // Unused op codes.
        run_op(4'd2, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 5'd3);
        run_op(4'd11, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd3);
        gap();

        // Randomized operations, sometimes back to back.
        for (int i = 0; i < 250; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) ra[31] = rb[31];
            run_op(4'($urandom), 1'($urandom_range(0, 1)), ra, rb, 5'($urandom));
            if ($urandom_range(0, 3) != 0) gap();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
